// File: rtl/spi_flash_responder_if.sv
// Pin bundle between the SPI flash responder, its SPI master and its byte memory.
// mem_rd is a one-clk strobe with mem_addr valid alongside; mem_rdata must be valid exactly one clk later (no stall).
interface spi_flash_responder_if #(
   parameter int MEM_AW = 12
);
   logic              spi_sck;
   logic              spi_cs_n;
   logic              spi_si;
   logic              spi_so;
   logic              spi_so_oe;
   logic              mem_rd;
   logic [MEM_AW-1:0] mem_addr;
   logic [7:0]        mem_rdata;

   modport slave (
      input  spi_sck, spi_cs_n, spi_si, mem_rdata,
      output spi_so, spi_so_oe, mem_rd, mem_addr
   );

   modport master (
      output spi_sck, spi_cs_n, spi_si, mem_rdata,
      input  spi_so, spi_so_oe, mem_rd, mem_addr
   );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target answering READ (0x03) and RDID (0x9F), fully oversampled in the clk domain.
// READ bytes come from a one-clk-latency synchronous byte memory; the next byte is prefetched after bit 0 goes out.
module spi_flash_responder #(
   parameter int          MEM_AW  = 12,
   parameter logic [23:0] ID_WORD = 24'h010216,
   parameter int          SYNC    = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   spi_flash_responder_if.slave bus,
   output logic                 busy,
   output logic [7:0]           last_cmd,
   output logic [2:0]           state_dbg
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      DATA   = 3'd3,
      ID     = 3'd4,
      IGNORE = 3'd5
   } state_t;

   localparam logic [MEM_AW-1:0] ADDR_ONE = 1;

   state_t            state;
   logic [SYNC-1:0]   sck_sync, cs_sync, si_sync;
   logic              sck_q, cs_q;
   logic [4:0]        bit_cnt;
   logic [6:0]        cmd_sr;
   logic [22:0]       addr_sr;
   logic [MEM_AW-1:0] addr_reg;
   logic [7:0]        tx_sr;
   logic              cap;

   logic              s_sck, s_cs, s_si;
   logic              rise, fall, cs_fall, cs_rise;
   logic [7:0]        cmd_byte;
   logic [23:0]       addr_full;
   logic [MEM_AW-1:0] addr_next;

   assign s_sck     = sck_sync[SYNC-1];
   assign s_cs      = cs_sync[SYNC-1];
   assign s_si      = si_sync[SYNC-1];
   assign rise      = s_sck & ~sck_q & ~s_cs;
   assign fall      = ~s_sck & sck_q & ~s_cs;
   assign cs_fall   = cs_q & ~s_cs;
   assign cs_rise   = ~cs_q & s_cs;
   assign cmd_byte  = {cmd_sr, s_si};
   assign addr_full = {addr_sr, s_si};
   assign addr_next = addr_reg + ADDR_ONE;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync <= '0;
         cs_sync  <= '1;
         si_sync  <= '0;
         sck_q    <= 1'b0;
         cs_q     <= 1'b1;
      end else begin
         sck_sync <= {sck_sync[SYNC-2:0], bus.spi_sck};
         cs_sync  <= {cs_sync[SYNC-2:0], bus.spi_cs_n};
         si_sync  <= {si_sync[SYNC-2:0], bus.spi_si};
         sck_q    <= s_sck;
         cs_q     <= s_cs;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         bus.spi_so    <= 1'b0;
         bus.spi_so_oe <= 1'b0;
         bus.mem_rd    <= 1'b0;
         bus.mem_addr  <= '0;
         busy          <= 1'b0;
         last_cmd      <= 8'h00;
         bit_cnt       <= '0;
         cmd_sr        <= '0;
         addr_sr       <= '0;
         addr_reg      <= '0;
         tx_sr         <= '0;
         cap           <= 1'b0;
      end else begin
         bus.mem_rd <= 1'b0;
         cap        <= bus.mem_rd;
         if (cs_rise) begin
            // Deselect wins over everything, including a fetch already in flight.
            state         <= IDLE;
            bus.spi_so_oe <= 1'b0;
            bit_cnt       <= '0;
            busy          <= 1'b0;
            cap           <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     state   <= CMD;
                     busy    <= 1'b1;
                     bit_cnt <= '0;
                  end
               end
               CMD: begin
                  if (rise) begin
                     cmd_sr <= cmd_byte[6:0];
                     if (bit_cnt == 5'd7) begin
                        last_cmd <= cmd_byte;
                        bit_cnt  <= '0;
                        case (cmd_byte)
                           8'h03: state <= ADDR;
                           8'h9F: begin
                              state         <= ID;
                              bus.spi_so_oe <= 1'b1;
                              bus.spi_so    <= ID_WORD[23];
                           end
                           default: state <= IGNORE;
                        endcase
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               ADDR: begin
                  if (rise) begin
                     addr_sr <= addr_full[22:0];
                     if (bit_cnt == 5'd23) begin
                        addr_reg      <= addr_full[MEM_AW-1:0];
                        bus.mem_addr  <= addr_full[MEM_AW-1:0];
                        bus.mem_rd    <= 1'b1;
                        bus.spi_so_oe <= 1'b1;
                        bit_cnt       <= '0;
                        state         <= DATA;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               DATA: begin
                  // bit_cnt counts rises within the byte; the fall at count 0 presents bit 7.
                  if (rise) begin
                     bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                  end else if (fall) begin
                     if (bit_cnt == 5'd0) begin
                        bus.spi_so <= tx_sr[7];
                     end else begin
                        tx_sr      <= {tx_sr[6:0], 1'b0};
                        bus.spi_so <= tx_sr[6];
                        if (bit_cnt == 5'd7) begin
                           bus.mem_rd   <= 1'b1;
                           bus.mem_addr <= addr_next;
                           addr_reg     <= addr_next;
                        end
                     end
                  end
               end
               ID: begin
                  if (rise) begin
                     bit_cnt <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
                  end else if (fall) begin
                     bus.spi_so <= ID_WORD[5'd23 - bit_cnt];
                  end
               end
               default: ;
            endcase
            // Only the first byte of a READ is captured before any data fall, so it goes straight to so.
            if (cap) begin
               tx_sr <= bus.mem_rdata;
               if (bit_cnt == 5'd0) bus.spi_so <= bus.mem_rdata[7];
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: a mode-0 SPI master task set, a byte memory, and a frame-level reference model.
module tb_spi_flash_responder;
   localparam int          MEM_AW  = 12;
   localparam int          DEPTH   = 1 << MEM_AW;
   localparam logic [23:0] ID_WORD = 24'h010216;
   localparam int          SYNC    = 2;
   localparam int          HALF    = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              busy;
   logic [7:0]        last_cmd;
   logic [2:0]        state_dbg;

   spi_flash_responder_if #(.MEM_AW(MEM_AW)) bus ();

   spi_flash_responder #(
      .MEM_AW (MEM_AW),
      .ID_WORD(ID_WORD),
      .SYNC   (SYNC)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .busy     (busy),
      .last_cmd (last_cmd),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   logic [7:0]        mem [0:DEPTH-1];
   logic [MEM_AW-1:0] rd_log [$];
   int                oe_cycles = 0;
   logic [7:0]        exp_q [$];
   logic [MEM_AW-1:0] exp_addr_q [$];
   int                n_checks = 0;
   int                n_errors = 0;

   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
   end

   always @(negedge clk) begin
      if (bus.mem_rd) rd_log.push_back(bus.mem_addr);
      if (bus.spi_so_oe) oe_cycles++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic spi_bit(input logic mosi, output logic miso, output logic oe);
      @(negedge clk) bus.spi_si = mosi;
      repeat (HALF) @(negedge clk);
      miso = bus.spi_so;
      oe   = bus.spi_so_oe;
      bus.spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic oe_all);
      logic b, oe;
      oe_all = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], b, oe);
         rx[i]  = b;
         oe_all = oe_all & oe;
      end
   endtask

   task automatic cs_begin();
      @(negedge clk) bus.spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_end();
      repeat (4) @(negedge clk);
      bus.spi_cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   function automatic logic [7:0] id_byte(input int i);
      logic [23:0] w;
      w = ID_WORD >> (8 * (2 - (i % 3)));
      return w[7:0];
   endfunction

   // A READ of n bytes fetches addr..addr+n-1, plus one prefetch issued once bit 0 of the last byte is out.
   task automatic do_read(input logic [23:0] a, input int n, input string tag);
      logic [7:0] rx;
      logic       oe;
      int         start, base;
      base  = int'(a[MEM_AW-1:0]);
      start = rd_log.size();
      for (int i = 0; i < n; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
      for (int i = 0; i <= n; i++) exp_addr_q.push_back(MEM_AW'((base + i) % DEPTH));
      cs_begin();
      spi_byte(8'h03, rx, oe);
      spi_byte(a[23:16], rx, oe);
      spi_byte(a[15:8], rx, oe);
      spi_byte(a[7:0], rx, oe);
      for (int i = 0; i < n; i++) begin
         spi_byte(8'($urandom), rx, oe);
         check_val({tag, " data"}, rx, exp_q.pop_front());
         check_val({tag, " oe"}, oe, 1);
      end
      cs_end();
      check_val({tag, " last_cmd"}, last_cmd, 8'h03);
      check_val({tag, " rd_count"}, rd_log.size() - start, n + 1);
      for (int i = 0; i <= n; i++) begin
         logic [31:0] got;
         got = (start + i < rd_log.size()) ? 32'(rd_log[start + i]) : 32'hDEAD_BEEF;
         check_val({tag, " rd_addr"}, got, 32'(exp_addr_q.pop_front()));
      end
   endtask

   task automatic do_rdid(input int n, input string tag);
      logic [7:0] rx;
      logic       oe;
      int         start;
      start = rd_log.size();
      for (int i = 0; i < n; i++) exp_q.push_back(id_byte(i));
      cs_begin();
      spi_byte(8'h9F, rx, oe);
      for (int i = 0; i < n; i++) begin
         spi_byte(8'($urandom), rx, oe);
         check_val({tag, " id"}, rx, exp_q.pop_front());
         check_val({tag, " oe"}, oe, 1);
      end
      cs_end();
      check_val({tag, " last_cmd"}, last_cmd, 8'h9F);
      check_val({tag, " rd_count"}, rd_log.size() - start, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, " so"}, bus.spi_so, 0);
      check_val({tag, " so_oe"}, bus.spi_so_oe, 0);
      check_val({tag, " mem_rd"}, bus.mem_rd, 0);
      check_val({tag, " mem_addr"}, bus.mem_addr, 0);
      check_val({tag, " busy"}, busy, 0);
      check_val({tag, " last_cmd"}, last_cmd, 0);
   endtask

   initial begin
      logic [7:0] rx;
      logic       b, oe;
      int         start, oe_start;
      bus.spi_sck  = 1'b0;
      bus.spi_cs_n = 1'b1;
      bus.spi_si   = 1'b0;
      for (int n = 0; n < DEPTH; n++) mem[n] = 8'(n) ^ 8'hA5;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      do_read(24'h000010, 4, "t1_read");
      do_read(24'h000FFE, 3, "t2_wrap");
      do_rdid(6, "t3_rdid");

      start    = rd_log.size();
      oe_start = oe_cycles;
      cs_begin();
      spi_byte(8'h05, rx, oe);
      spi_byte(8'h00, rx, oe);
      spi_byte(8'h00, rx, oe);
      cs_end();
      check_val("t4_unknown oe", oe_cycles - oe_start, 0);
      check_val("t4_unknown last_cmd", last_cmd, 8'h05);
      check_val("t4_unknown rd_count", rd_log.size() - start, 0);
      do_read(24'h000123, 2, "t4_after");

      cs_begin();
      spi_byte(8'h03, rx, oe);
      spi_byte(8'h00, rx, oe);
      spi_byte(8'h00, rx, oe);
      spi_byte(8'h40, rx, oe);
      for (int i = 0; i < 3; i++) spi_bit(1'b0, b, oe);
      repeat (2) @(negedge clk);
      check_val("t5_abort busy_mid", busy, 1);
      bus.spi_cs_n = 1'b1;
      repeat (SYNC + 1) @(negedge clk);
      check_val("t5_abort so_oe", bus.spi_so_oe, 0);
      check_val("t5_abort busy", busy, 0);
      repeat (8) @(negedge clk);
      do_read(24'h000000, 1, "t5_after");

      cs_begin();
      spi_byte(8'h03, rx, oe);
      spi_byte(8'h12, rx, oe);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1 check_reset_outputs("t6_reset");
      bus.spi_cs_n = 1'b1;
      bus.spi_sck  = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      do_read(24'h000777, 2, "t6_after");

      for (int n = 0; n < DEPTH; n++) mem[n] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 3) == 0) do_rdid($urandom_range(1, 4), "rnd_rdid");
         else do_read(24'($urandom), $urandom_range(1, 4), "rnd_read");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
